alert_check_scheduler: RTL and testbench

Periodic check scheduler for the alertness-detection datapath. It decides when the next driver-response check is launched. It starts one check per interval through a start/done handshake with the check engine (the WDT-based LED/buzzer unit). It adapts the next interval to the response grade, counts consecutive misses, and latches a master alarm that only the operator can clear.

---
 rtl/alert_check_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_alert_check_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alert_check_scheduler.sv
// alert_check_scheduler
// Periodic check scheduler for the alertness-detection datapath. Launches one
// driver-response check per interval through a start/done handshake with the
// check engine, adapts the next interval to the response grade, counts
// consecutive misses and latches a master alarm until the operator clears it.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-high; clears all state
//   enable       scheduler run enable (level)
//   chk_start    one-cycle pulse launching a check
//   chk_done     one-cycle pulse: check finished
//   chk_grade    result with chk_done: 0 green, 1 yellow, 2 red, 3 miss
//   alarm_clr    operator clear of the latched alarm
//   alarm        latched master alarm
//   miss_cnt     consecutive-miss count, saturating at 3
//   busy         high while a check is outstanding
//
// Optional feature macro ALERT_SCHED_STATS_EN adds:
//   stat_checks  completed checks (timeouts included), saturating
//   stat_alarms  entries into ALARM, saturating
module alert_check_scheduler #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned IVL_LONG   = 400,
    parameter int unsigned IVL_MID    = 200,
    parameter int unsigned IVL_SHORT  = 100,
    parameter int unsigned DONE_TMO   = 1000,
    parameter int unsigned MISS_LIMIT = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    output logic       chk_start,
    input  logic       chk_done,
    input  logic [1:0] chk_grade,
    input  logic       alarm_clr,
    output logic       alarm,
    output logic [1:0] miss_cnt,
    output logic       busy
`ifdef ALERT_SCHED_STATS_EN
    ,
    output logic [15:0] stat_checks,
    output logic [7:0]  stat_alarms
`endif
);

    localparam logic [CNT_W-1:0] LOAD_LONG  = CNT_W'(IVL_LONG);
    localparam logic [CNT_W-1:0] LOAD_MID   = CNT_W'(IVL_MID);
    localparam logic [CNT_W-1:0] LOAD_SHORT = CNT_W'(IVL_SHORT);
    localparam logic [CNT_W-1:0] LOAD_TMO   = CNT_W'(DONE_TMO);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_START,
        S_BUSY,
        S_ALARM
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [CNT_W-1:0] tmo, tmo_d;
    logic [1:0]       miss_d;
    logic [1:0]       miss_inc;
    logic [1:0]       eff_grade;
    logic             finish;

    // Saturating post-increment miss count, used for both update and alarm test
    assign miss_inc = (miss_cnt == 2'd3) ? 2'd3 : miss_cnt + 2'd1;

    // Check completes on chk_done, or on the last BUSY cycle (tmo about to hit 0)
    assign finish    = (state == S_BUSY) && (chk_done || (tmo <= CNT_ONE));
    // chk_done wins over a coincident timeout
    assign eff_grade = chk_done ? chk_grade : 2'd3;

    // Next-state and next-counter logic
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        tmo_d   = tmo;
        miss_d  = miss_cnt;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    cnt_d   = LOAD_SHORT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Zero is observed for one cycle before START: interval + 2 latency
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (cnt == '0) begin
                    state_d = S_START;
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end
            S_START: begin
                tmo_d   = LOAD_TMO;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (finish) begin
                    case (eff_grade)
                        2'd0: begin
                            cnt_d  = LOAD_LONG;
                            miss_d = 2'd0;
                        end
                        2'd1: begin
                            cnt_d  = LOAD_MID;
                            miss_d = 2'd0;
                        end
                        2'd2: begin
                            cnt_d  = LOAD_SHORT;
                            miss_d = 2'd0;
                        end
                        default: begin
                            cnt_d  = LOAD_SHORT;
                            miss_d = miss_inc;
                        end
                    endcase
                    if ((eff_grade == 2'd3) && (32'(miss_inc) >= MISS_LIMIT)) begin
                        state_d = S_ALARM;
                    end else if (!enable) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    tmo_d = tmo - CNT_ONE;
                end
            end
            S_ALARM: begin
                if (alarm_clr) begin
                    miss_d  = 2'd0;
                    cnt_d   = LOAD_SHORT;
                    state_d = enable ? S_WAIT : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= LOAD_SHORT;
            tmo       <= '0;
            miss_cnt  <= 2'd0;
            chk_start <= 1'b0;
            busy      <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            tmo       <= tmo_d;
            miss_cnt  <= miss_d;
            chk_start <= (state_d == S_START);
            busy      <= (state_d == S_BUSY);
            alarm     <= (state_d == S_ALARM);
        end
    end

`ifdef ALERT_SCHED_STATS_EN
    logic alarm_entry;

    assign alarm_entry = (state_d == S_ALARM) && (state != S_ALARM);

    // Saturating statistics counters; untouched by alarm_clr
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_checks <= 16'd0;
            stat_alarms <= 8'd0;
        end else begin
            if (finish && (stat_checks != 16'hFFFF)) begin
                stat_checks <= stat_checks + 16'd1;
            end
            if (alarm_entry && (stat_alarms != 8'hFF)) begin
                stat_alarms <= stat_alarms + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alert_check_scheduler.sv
module tb_alert_check_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       chk_start;
    logic       chk_done = 1'b0;
    logic [1:0] chk_grade = 2'd0;
    logic       alarm_clr = 1'b0;
    logic       alarm;
    logic [1:0] miss_cnt;
    logic       busy;
`ifdef ALERT_SCHED_STATS_EN
    logic [15:0] stat_checks;
    logic [7:0]  stat_alarms;
`endif

    int errors = 0;
    int checks = 0;
    int exp_checks = 0;
    int exp_alarms = 0;

    alert_check_scheduler #(
        .CNT_W(16), .IVL_LONG(8), .IVL_MID(6), .IVL_SHORT(4),
        .DONE_TMO(10), .MISS_LIMIT(3)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .chk_start(chk_start), .chk_done(chk_done), .chk_grade(chk_grade),
        .alarm_clr(alarm_clr), .alarm(alarm), .miss_cnt(miss_cnt), .busy(busy)
`ifdef ALERT_SCHED_STATS_EN
        , .stat_checks(stat_checks), .stat_alarms(stat_alarms)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] grade;
        int         delay;
        int         lat;
        int         miss;
        int         alm;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Counts edges until chk_start is seen; returns budget if never seen
    task automatic wait_start(input int budget, output int n);
        n = 0;
        while (!chk_start && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic check_stats(input string tag);
`ifdef ALERT_SCHED_STATS_EN
        check({tag, "_stat_checks"}, int'(stat_checks), exp_checks);
        check({tag, "_stat_alarms"}, int'(stat_alarms), exp_alarms);
`else
        exp_checks = exp_checks + 0;
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        // grade, busy delay, latency done->start, miss_cnt, alarm
        vecs[0] = '{2'd0, 2, 10, 0, 0};
        vecs[1] = '{2'd1, 0,  8, 0, 0};
        vecs[2] = '{2'd2, 9,  6, 0, 0};   // done on the timeout cycle: done wins
        vecs[3] = '{2'd3, 1,  6, 1, 0};
        vecs[4] = '{2'd3, 3,  6, 2, 0};
        vecs[5] = '{2'd3, 0,  0, 3, 1};

        // Reset state
        tick(); tick();
        check("rst_chk_start", int'(chk_start), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_alarm", int'(alarm), 0);
        check("rst_miss_cnt", int'(miss_cnt), 0);
        check_stats("rst");
        reset = 1'b0;
        tick();

        // First start after enable
        enable = 1'b1;
        wait_start(40, n);
        check("first_start_lat", n, 6);
        tick();
        check("first_busy", int'(busy), 1);
        check("start_one_cycle", int'(chk_start), 0);

        // Graded responses
        for (int i = 0; i < 6; i++) begin
            repeat (vecs[i].delay) tick();
            chk_done  = 1'b1;
            chk_grade = vecs[i].grade;
            tick();
            chk_done  = 1'b0;
            exp_checks++;
            if (vecs[i].alm != 0) exp_alarms++;
            check($sformatf("vec%0d_miss_cnt", i), int'(miss_cnt), vecs[i].miss);
            check($sformatf("vec%0d_alarm", i), int'(alarm), vecs[i].alm);
            if (vecs[i].alm == 0) begin
                wait_start(40, n);
                check($sformatf("vec%0d_latency", i), n + 1, vecs[i].lat);
                tick();
                check($sformatf("vec%0d_busy", i), int'(busy), 1);
            end else begin
                wait_start(50, n);
                check($sformatf("vec%0d_no_start", i), int'(chk_start), 0);
                check($sformatf("vec%0d_alarm_held", i), int'(alarm), 1);
            end
        end

        // Clear alarm with enable low: back to IDLE, no checks
        enable    = 1'b0;
        alarm_clr = 1'b1;
        tick();
        alarm_clr = 1'b0;
        check("clr_idle_alarm", int'(alarm), 0);
        check("clr_idle_miss", int'(miss_cnt), 0);
        check_stats("clr_idle");
        wait_start(20, n);
        check("clr_idle_no_start", int'(chk_start), 0);
        enable = 1'b1;
        wait_start(40, n);
        check("reenable_lat", n, 6);

        // Never answer: three timeouts raise the alarm
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("tmo%0d_busy", k), int'(busy), 1);
            n = 0;
            while (busy && n < 50) begin
                n++;
                tick();
            end
            exp_checks++;
            if (k == 3) exp_alarms++;
            check($sformatf("tmo%0d_busy_len", k), n, 10);
            check($sformatf("tmo%0d_miss_cnt", k), int'(miss_cnt), k);
            check($sformatf("tmo%0d_alarm", k), int'(alarm), (k == 3) ? 1 : 0);
            if (k < 3) begin
                wait_start(40, n);
                check($sformatf("tmo%0d_next_lat", k), n + 1, 6);
            end
        end

        // Clear with enable high: restart after short interval
        alarm_clr = 1'b1;
        tick();
        alarm_clr = 1'b0;
        check("clr_alarm", int'(alarm), 0);
        check("clr_miss", int'(miss_cnt), 0);
        check_stats("clr_run");
        wait_start(40, n);
        check("clr_start_lat", n + 1, 6);

        // Drop enable mid-BUSY: check completes, then IDLE
        tick();
        tick();
        enable = 1'b0;
        tick();
        tick();
        check("noen_busy_held", int'(busy), 1);
        chk_done  = 1'b1;
        chk_grade = 2'd0;
        tick();
        chk_done  = 1'b0;
        exp_checks++;
        check("noen_busy_off", int'(busy), 0);
        wait_start(30, n);
        check("noen_no_start", int'(chk_start), 0);

        // Reset mid-WAIT with a nonzero miss count
        enable = 1'b1;
        wait_start(40, n);
        check("pre_rst_lat", n, 6);
        tick();
        chk_done  = 1'b1;
        chk_grade = 2'd3;
        tick();
        chk_done  = 1'b0;
        exp_checks++;
        check("pre_rst_miss", int'(miss_cnt), 1);
        tick();
        tick();
        check_stats("pre_rst");
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_miss", int'(miss_cnt), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_alarm", int'(alarm), 0);
        check("async_rst_start", int'(chk_start), 0);
        chk_done  = 1'b1;
        chk_grade = 2'd3;
        tick();
        chk_done  = 1'b0;
        exp_checks = 0;
        exp_alarms = 0;
        check_stats("post_rst");
        tick();
        reset = 1'b0;
        wait_start(40, n);
        check("post_rst_lat", n, 6);
        check("post_rst_miss", int'(miss_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
